// File: rtl/axil_reg_bridge_pkg.sv
// Shared types for the AXI4-Lite register bridge: FSM state encodings and response codes.
package axil_reg_bridge_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_EXEC = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_EXEC = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns each write/read transaction into a single-cycle
// wr_en/rd_en strobe on a simple register interface. Read and write paths are independent.
module axil_reg_bridge
    import axil_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [31:0]           rd_data
);

    // ---------------------------------------------------------------- write path
    wr_state_e             wstate_q, wstate_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]           wr_data_q;
    logic [3:0]            wr_strb_q;
    logic                  aw_hs, w_hs;

    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid & wready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // Readies are registered from the next state so they never depend on valid combinationally.
    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs) aw_got_d = 1'b1;
                if (w_hs)  w_got_d  = 1'b1;
                if (aw_got_d && w_got_d) begin
                    wstate_d = W_EXEC;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            W_EXEC: wstate_d = W_RESP;
            W_RESP: if (s_axi_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE) && !aw_got_d;
        wready_d  = (wstate_d == W_IDLE) && !w_got_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (aw_hs) wr_addr_q <= {s_axi_awaddr[ADDR_WIDTH-1:2], 2'b00};
            if (w_hs) begin
                wr_data_q <= s_axi_wdata;
                wr_strb_q <= s_axi_wstrb;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = RESP_OKAY;
    assign wr_en         = (wstate_q == W_EXEC);
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_strb       = wr_strb_q;

    // ----------------------------------------------------------------- read path
    rd_state_e             rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [31:0]           rdata_q;
    logic                  ar_hs;

    assign ar_hs = s_axi_arvalid & arready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_EXEC;
            R_EXEC:  rstate_d = R_RESP;
            R_RESP:  if (s_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (ar_hs) rd_addr_q <= {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
            if (rstate_q == R_EXEC) rdata_q <= rd_data;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (rstate_q == R_RESP);
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rdata   = rdata_q;
    assign rd_en         = (rstate_q == R_EXEC);
    assign rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed bench for axil_reg_bridge with a small register-file core model and
// scoreboard queues checked when the DUT strobes the core or completes a response.
module tb_axil_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr, wr_addr, rd_addr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, wr_data, rd_data;
    logic [3:0]  wstrb, wr_strb;
    logic [1:0]  bresp, rresp;
    logic        wr_en, rd_en;

    always #5 clk = ~clk;

    axil_reg_bridge #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data)
    );

    // Core model: four-word register file with byte enables, combinational read.
    logic [31:0] mem [4];
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 32'h8000_0003;
            mem[1] <= 32'h0;
            mem[2] <= 32'h0;
            mem[3] <= 32'hCAFE_F00D;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem[wr_addr[3:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end
    assign rd_data = rd_en ? mem[rd_addr[3:2]] : 32'h0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [3:0]  rda_q[$];
    logic [31:0] rdd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          snap;
    wr_exp_t     we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pop on core strobes and on completed AXI responses.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                we = wr_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(we.addr));
                chk("wr_data", wr_data, we.data);
                chk("wr_strb", 32'(wr_strb), 32'(we.strb));
            end
        end
        if (rd_en === 1'b1) begin
            rd_cnt++;
            chk("rd_expected", 32'(rda_q.size() > 0), 32'd1);
            if (rda_q.size() > 0) chk("rd_addr", 32'(rd_addr), 32'(rda_q.pop_front()));
        end
        if (bvalid === 1'b1 && bready === 1'b1) chk("bresp", 32'(bresp), 32'd0);
        if (rvalid === 1'b1 && rready === 1'b1) begin
            chk("rresp", 32'(rresp), 32'd0);
            chk("r_expected", 32'(rdd_q.size() > 0), 32'd1);
            if (rdd_q.size() > 0) chk("rdata", rdata, rdd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (3) tick();
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();
        chk("idle_awready", 32'(awready), 1);
        chk("idle_wready", 32'(wready), 1);
        chk("idle_arready", 32'(arready), 1);

        // AW and W in the same cycle
        wr_q.push_back('{addr: 4'h4, data: 32'h5, strb: 4'hF});
        awaddr = 4'h4; awvalid = 1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t1_wr_en_c1", 32'(wr_en), 1);
        chk("t1_wr_addr_c1", 32'(wr_addr), 32'h4);
        chk("t1_awready_c1", 32'(awready), 0);
        tick();
        chk("t1_bvalid_c2", 32'(bvalid), 1);
        chk("t1_wr_en_c2", 32'(wr_en), 0);
        tick();
        chk("t1_bvalid_c3", 32'(bvalid), 0);
        chk("t1_awready_c3", 32'(awready), 1);

        // W three cycles ahead of AW, response held off
        snap = wr_cnt;
        bready = 0;
        wr_q.push_back('{addr: 4'h8, data: 32'h1, strb: 4'hF});
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        chk("t2_wready_held", 32'(wready), 0);
        chk("t2_awready_open", 32'(awready), 1);
        tick();
        tick();
        chk("t2_no_early_wr", 32'(wr_cnt), 32'(snap));
        awaddr = 4'h8; awvalid = 1;
        tick();
        awvalid = 0;
        chk("t2_wr_en", 32'(wr_en), 1);
        tick();
        chk("t2_bvalid", 32'(bvalid), 1);
        chk("t2_awready_resp", 32'(awready), 0);
        chk("t2_wready_resp", 32'(wready), 0);
        tick();
        tick();
        chk("t2_bvalid_hold", 32'(bvalid), 1);
        chk("t2_one_wr", 32'(wr_cnt), 32'(snap + 1));
        bready = 1;
        tick();
        chk("t2_bvalid_done", 32'(bvalid), 0);
        chk("t2_awready_back", 32'(awready), 1);
        chk("t2_one_wr_final", 32'(wr_cnt), 32'(snap + 1));

        // Read of address 0
        rda_q.push_back(4'h0); rdd_q.push_back(32'h8000_0003);
        araddr = 4'h0; arvalid = 1; rready = 1;
        tick();
        arvalid = 0;
        chk("t3_rd_en_c1", 32'(rd_en), 1);
        chk("t3_arready_c1", 32'(arready), 0);
        tick();
        chk("t3_rvalid_c2", 32'(rvalid), 1);
        chk("t3_rdata_c2", rdata, 32'h8000_0003);
        tick();
        chk("t3_rvalid_c3", 32'(rvalid), 0);
        chk("t3_arready_c3", 32'(arready), 1);

        // rready held low for 10 cycles while a second read waits
        rda_q.push_back(4'h4); rdd_q.push_back(32'h5);
        rready = 0; araddr = 4'h4; arvalid = 1;
        tick();
        arvalid = 0;
        tick();
        snap = rd_cnt;
        araddr = 4'hC; arvalid = 1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_rvalid_hold", 32'(rvalid), 1);
            chk("t4_rdata_hold", rdata, 32'h5);
            chk("t4_arready_blocked", 32'(arready), 0);
            tick();
        end
        chk("t4_no_extra_rd", 32'(rd_cnt), 32'(snap));
        rda_q.push_back(4'hC); rdd_q.push_back(32'hCAFE_F00D);
        rready = 1;
        tick();
        chk("t4_rvalid_done", 32'(rvalid), 0);
        chk("t4_arready_back", 32'(arready), 1);
        tick();
        arvalid = 0;
        chk("t4_second_rd_en", 32'(rd_en), 1);
        tick();
        chk("t4_second_rdata", rdata, 32'hCAFE_F00D);
        tick();

        // Concurrent write 0x8 and misaligned read 0xB; read sees the pre-write value
        wr_q.push_back('{addr: 4'h8, data: 32'hA5A5_0000, strb: 4'hC});
        rda_q.push_back(4'h8); rdd_q.push_back(32'h1);
        awaddr = 4'h8; awvalid = 1; wdata = 32'hA5A5_0000; wstrb = 4'hC; wvalid = 1;
        araddr = 4'hB; arvalid = 1; bready = 1; rready = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t5_wr_en", 32'(wr_en), 1);
        chk("t5_rd_en", 32'(rd_en), 1);
        tick();
        chk("t5_bvalid", 32'(bvalid), 1);
        chk("t5_rvalid", 32'(rvalid), 1);
        tick();

        // Reset in the capture cycle aborts the write
        snap = wr_cnt;
        awaddr = 4'h4; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
        rst = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t6_wr_en_rst", 32'(wr_en), 0);
        chk("t6_bvalid_rst", 32'(bvalid), 0);
        chk("t6_awready_rst", 32'(awready), 0);
        chk("t6_wready_rst", 32'(wready), 0);
        tick();
        rst = 0;
        tick();
        chk("t6_awready_after", 32'(awready), 1);
        chk("t6_wready_after", 32'(wready), 1);
        tick();
        chk("t6_no_wr", 32'(wr_cnt), 32'(snap));
        chk("t6_bvalid_after", 32'(bvalid), 0);

        // Recovery: misaligned partial write then read back
        wr_q.push_back('{addr: 4'hC, data: 32'h1234_5678, strb: 4'h3});
        awaddr = 4'hE; awvalid = 1; wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("t7_bvalid", 32'(bvalid), 1);
        tick();
        rda_q.push_back(4'hC); rdd_q.push_back(32'hCAFE_5678);
        araddr = 4'hC; arvalid = 1;
        tick();
        arvalid = 0;
        tick();
        chk("t7_rvalid", 32'(rvalid), 1);
        repeat (3) tick();

        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("rda_q_drained", 32'(rda_q.size()), 0);
        chk("rdd_q_drained", 32'(rdd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
